// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw level in,
// debounced level and event pulses out.
interface switch_debouncer_if;
  logic i_switch;
  logic o_switch;
  logic o_press;
  logic o_release;
  logic o_click;
  logic o_long_press;

  modport master (
    input  i_switch,
    output o_switch,
    output o_press,
    output o_release,
    output o_click,
    output o_long_press
  );

  modport slave (
    output i_switch,
    input  o_switch,
    input  o_press,
    input  o_release,
    input  o_click,
    input  o_long_press
  );
endinterface

// File: rtl/switch_debouncer.sv
// Raw switch -> synchronizer -> stability debouncer
// -> press classifier (press/release/click/long).
module switch_debouncer #(
  parameter int unsigned c_DEBOUNCE_COUNT   = 500000,
  parameter int unsigned c_LONG_PRESS_COUNT = 50000000
) (
  input logic                 i_clk,
  input logic                 i_rst,
  switch_debouncer_if.master  sw
);

  localparam logic [31:0] DB_LAST =
    32'(c_DEBOUNCE_COUNT - 1);
  localparam logic [31:0] LP_LAST =
    32'(c_LONG_PRESS_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  logic        r_sync_1;
  logic        r_sync_2;
  logic        r_switch;
  logic [31:0] r_db_cnt;

  state_t      r_state;
  state_t      w_state;
  logic [31:0] r_hold;
  logic [31:0] w_hold;

  logic r_press, w_press;
  logic r_release, w_release;
  logic r_click, w_click;
  logic r_long, w_long;

  logic w_mismatch;
  logic w_accept;
  logic w_rise;
  logic w_fall;

  assign w_mismatch = r_sync_2 != r_switch;
  assign w_accept   = w_mismatch &&
                      (r_db_cnt == DB_LAST);
  assign w_rise     = w_accept && r_sync_2;
  assign w_fall     = w_accept && !r_sync_2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync_1 <= 1'b0;
      r_sync_2 <= 1'b0;
      r_switch <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync_1 <= sw.i_switch;
      r_sync_2 <= r_sync_1;
      if (!w_mismatch) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_switch <= r_sync_2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 32'd1;
      end
    end
  end

  // Edge events are decoded from the debouncer's
  // accept so the pulses land on the o_switch edge.
  always_comb begin
    w_state   = r_state;
    w_hold    = r_hold;
    w_press   = 1'b0;
    w_release = 1'b0;
    w_click   = 1'b0;
    w_long    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state = PRESSED;
          w_press = 1'b1;
          w_hold  = '0;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state   = IDLE;
          w_release = 1'b1;
          w_click   = 1'b1;
        end else if (r_hold == LP_LAST) begin
          w_state = LONG;
          w_long  = 1'b1;
        end else begin
          w_hold = r_hold + 32'd1;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_state   = IDLE;
          w_release = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_hold    <= w_hold;
      r_press   <= w_press;
      r_release <= w_release;
      r_click   <= w_click;
      r_long    <= w_long;
    end
  end

  assign sw.o_switch     = r_switch;
  assign sw.o_press      = r_press;
  assign sw.o_release    = r_release;
  assign sw.o_click      = r_click;
  assign sw.o_long_press = r_long;

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input-side companion to the LED blinker: conditions a raw mechanical switch into clean, clock-synchronous level and event signals. The block contains a 2-flop synchronizer, a stability-count debouncer and a three-state press classifier that emits press, release, click (short press) and long-press pulses. It sits between a board switch pin (50 MHz clock domain) and any control logic that consumes user input.

## Interface
- c_DEBOUNCE_COUNT, 500000: consecutive cycles of mismatch needed to accept a new switch level (10 ms at 50 MHz); legal range 1 to 2^32-1.
- c_LONG_PRESS_COUNT, 50000000: cycles a debounced press must be held to count as a long press (1 s at 50 MHz); legal range 2 to 2^32-1.
- i_clk, input, 1: system clock, 50 MHz; all logic on posedge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_switch, input, 1: raw asynchronous switch level, 1 = pressed.
- o_switch, output, 1: debounced switch level.
- o_press, output, 1: one-cycle pulse when o_switch rises.
- o_release, output, 1: one-cycle pulse when o_switch falls.
- o_click, output, 1: one-cycle pulse on a release that occurs before the long-press threshold.
- o_long_press, output, 1: one-cycle pulse when the hold time reaches c_LONG_PRESS_COUNT; at most once per press.

## Operation
- Synchronizer: r_sync_1 <= i_switch; r_sync_2 <= r_sync_1. Only r_sync_2 feeds downstream logic.
- Debounce counter (32 bit):
  - If r_sync_2 == o_switch, the counter clears to 0.
  - Otherwise, if counter == c_DEBOUNCE_COUNT-1, then o_switch <= r_sync_2 and the counter clears.
  - Otherwise the counter increments.
  - Any mismatch run shorter than c_DEBOUNCE_COUNT cycles is discarded with no output change.
- Press FSM, states IDLE, PRESSED, LONG; hold counter 32 bit:
  - IDLE: on a debounced rise, go to PRESSED, pulse o_press, clear the hold counter.
  - PRESSED: the hold counter increments each cycle.
    - If hold counter == c_LONG_PRESS_COUNT-1, go to LONG and pulse o_long_press.
    - On a debounced fall, go to IDLE and pulse o_release and o_click together.
  - LONG: the hold counter is frozen. On a debounced fall, go to IDLE and pulse o_release only (no o_click).
  - Debounced fall takes priority over reaching the long threshold in the same cycle: the result is a click, not a long press.
- All outputs are registered. Pulse outputs are high for exactly one cycle and never overlap except o_release with o_click.

## Timing
- Reset: on any edge with i_rst = 1:
  - both sync flops, both counters and o_switch go to 0;
  - the FSM goes to IDLE;
  - all pulse outputs go to 0, and no pulse is issued on that edge.
  - Reset mid-press abandons the press silently (no o_release or o_click).
- Press latency: edge 1 is the first edge sampling the new i_switch level; o_switch and o_press update at edge 2 + c_DEBOUNCE_COUNT. Release latency is identical.
- Long press: o_long_press is asserted c_LONG_PRESS_COUNT edges after the o_press edge.
- Switch held at 1 through reset release: treated as a new press; o_press fires 2 + c_DEBOUNCE_COUNT edges after the first edge with i_rst = 0.
- Counters never wrap. The debounce counter clears at c_DEBOUNCE_COUNT-1; the hold counter freezes in LONG.
- Minimum accepted pulse width on i_switch is c_DEBOUNCE_COUNT cycles, plus synchronizer metastability margin.

## Test plan
Common setup: c_DEBOUNCE_COUNT = 4, c_LONG_PRESS_COUNT = 10, 20 ns clock.
- Reset: i_rst = 1 for 3 edges with i_switch = 1 -> all outputs 0 throughout; o_press fires at the 6th edge after i_rst falls.
- Clean press: i_switch 0->1 and held -> o_switch = 1 and o_press = 1 at edge 6, o_press low at edge 7, no other pulses.
- Bounce: i_switch high 3 cycles, low 2, high 3, then low -> o_switch stays 0, zero pulses on every output.
- Short click: press debounced, hold 5 cycles, release cleanly -> o_release and o_click both pulse once, 6 edges after the release, no o_long_press.
- Long press: hold 20 cycles past o_press, then release:
  - o_long_press pulses once, exactly 10 edges after o_press, and does not repeat;
  - on release, o_release pulses and o_click stays 0.
- Reset mid-hold: i_rst for 1 edge, 5 cycles after o_press, with i_switch still 1:
  - outputs go to 0 and no o_long_press appears at the old deadline;
  - a fresh o_press fires 6 edges after reset release.
